// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, read-only cache in front of external
// tag/data RAMs (read data registered by the RAMs on the falling edge)
// and a word-wide backing memory. A miss refills the whole line one word
// at a time, writes the tag, and then compares again.
// Optional macro CACHE_STATS_EN enables the saturating hit/miss counters;
// without it HitCount/MissCount read as zero.
module cache_controller #(
    parameter int TAG_ADDR_WIDTH = 8,
    parameter int TAG_LENGTH     = 9,
    parameter int OFFSET_WIDTH   = 2,
    parameter int DATA_WIDTH     = 8,
    localparam int AW = TAG_LENGTH + TAG_ADDR_WIDTH + OFFSET_WIDTH
) (
    input  logic                                   Clk,
    input  logic                                   Reset_n,
    input  logic                                   CpuReq,
    input  logic [AW-1:0]                          CpuAddr,
    output logic                                   CpuReady,
    output logic [DATA_WIDTH-1:0]                  CpuData,
    input  logic                                   Flush,
    output logic [TAG_ADDR_WIDTH-1:0]              TagAddr,
    output logic [TAG_LENGTH-1:0]                  TagIn,
    output logic                                   TagWrite,
    input  logic [TAG_LENGTH-1:0]                  TagOut,
    output logic [TAG_ADDR_WIDTH+OFFSET_WIDTH-1:0] DataAddr,
    output logic [DATA_WIDTH-1:0]                  DataIn,
    output logic                                   DataWrite,
    input  logic [DATA_WIDTH-1:0]                  DataOut,
    output logic                                   MemReq,
    output logic [AW-1:0]                          MemAddr,
    input  logic                                   MemAck,
    input  logic [DATA_WIDTH-1:0]                  MemData,
    output logic [15:0]                            HitCount,
    output logic [15:0]                            MissCount
);

    typedef enum logic [2:0] {IDLE, COMPARE, REFILL, TAG_UPDATE, FLUSH} state_t;

    state_t                      state;
    logic [AW-1:0]               addr_q;
    logic [OFFSET_WIDTH-1:0]     counter;
    logic [2**TAG_ADDR_WIDTH-1:0] valid;
    logic                        ready_q;
    logic [DATA_WIDTH-1:0]       data_q;

    logic [TAG_LENGTH-1:0]       tag_q;
    logic [TAG_ADDR_WIDTH-1:0]   idx_q;
    logic [OFFSET_WIDTH-1:0]     off_q;
    logic [TAG_ADDR_WIDTH-1:0]   req_idx;
    logic [OFFSET_WIDTH-1:0]     req_off;
    logic                        hit;
    logic                        last_word;

    assign tag_q     = addr_q[AW-1 -: TAG_LENGTH];
    assign idx_q     = addr_q[OFFSET_WIDTH +: TAG_ADDR_WIDTH];
    assign off_q     = addr_q[OFFSET_WIDTH-1:0];
    assign req_idx   = CpuAddr[OFFSET_WIDTH +: TAG_ADDR_WIDTH];
    assign req_off   = CpuAddr[OFFSET_WIDTH-1:0];
    assign hit       = valid[idx_q] && (TagOut == tag_q);
    assign last_word = &counter;

    assign CpuReady = ready_q;
    assign CpuData  = data_q;

    // Controller FSM: request latch, refill word counter, valid bits, CPU response
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            counter <= '0;
            valid   <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Flush) begin
                        state <= FLUSH;
                    end else if (CpuReq) begin
                        addr_q <= CpuAddr;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        ready_q <= 1'b1;
                        data_q  <= DataOut;
                        state   <= IDLE;
                    end else begin
                        counter <= '0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (MemAck) begin
                        counter <= counter + 1'b1;
                        if (last_word) state <= TAG_UPDATE;
                    end
                end
                TAG_UPDATE: begin
                    // Line is complete: mark it valid, the next compare hits
                    valid[idx_q] <= 1'b1;
                    state        <= COMPARE;
                end
                FLUSH: begin
                    valid <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM and memory strobes decoded from the current state; the refill
    // write goes out in the same cycle as MemAck
    always_comb begin
        TagAddr   = '0;
        TagIn     = '0;
        TagWrite  = 1'b0;
        DataAddr  = '0;
        DataIn    = '0;
        DataWrite = 1'b0;
        MemReq    = 1'b0;
        MemAddr   = '0;
        case (state)
            IDLE: begin
                // Present the incoming address early so the RAMs have it
                // registered by the time COMPARE evaluates
                if (CpuReq) begin
                    TagAddr  = req_idx;
                    DataAddr = {req_idx, req_off};
                end
            end
            COMPARE: begin
                TagAddr  = idx_q;
                DataAddr = {idx_q, off_q};
            end
            REFILL: begin
                MemReq   = 1'b1;
                MemAddr  = {tag_q, idx_q, counter};
                TagAddr  = idx_q;
                DataAddr = {idx_q, counter};
                if (MemAck) begin
                    DataWrite = 1'b1;
                    DataIn    = MemData;
                end
            end
            TAG_UPDATE: begin
                TagWrite = 1'b1;
                TagIn    = tag_q;
                TagAddr  = idx_q;
                DataAddr = {idx_q, off_q};
            end
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        refilled;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    assign HitCount  = hit_count;
    assign MissCount = miss_count;

    // Saturating statistics; the compare that follows a refill is not a fresh hit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            refilled   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == TAG_UPDATE)  refilled <= 1'b1;
            else if (state == IDLE)   refilled <= 1'b0;
            if (state == COMPARE) begin
                if (hit) begin
                    if (!refilled && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`else
    assign HitCount  = '0;
    assign MissCount = '0;
`endif

endmodule
